// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the decode-stage register scoreboard.
package reg_scoreboard_pkg;

  localparam int SB_NREG   = 32;
  localparam int SB_CNT_W  = 2;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // r0 is hard-wired to zero and is never tracked.
  localparam reg_idx_t REG_ZERO = '0;

  // Width of the scoreboard->ID signals if they are later bundled:
  // ds_stall + busy_vec + err.
  localparam int SB_TO_DS_BUS_W = 1 + SB_NREG + 1;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode/memory/writeback event bundle into the scoreboard and its replies to ID.
interface reg_scoreboard_if
  import reg_scoreboard_pkg::*;
#(
  parameter int NREG = SB_NREG
);

  logic            ds_valid;
  reg_idx_t        ds_rj;
  logic            ds_rj_used;
  reg_idx_t        ds_rkd;
  logic            ds_rkd_used;
  reg_idx_t        ds_dest;
  logic            ds_gr_we;
  logic            ds_is_load;
  logic            ds_issue;
  logic            ms_ld_done;
  reg_idx_t        ms_ld_dest;
  logic            ws_we;
  reg_idx_t        ws_dest;
  logic            flush;
  logic            ds_stall;
  logic [NREG-1:0] busy_vec;
  logic            err;

  // Pipeline side: produces the events, consumes the interlock.
  modport master (
    output ds_valid, ds_rj, ds_rj_used, ds_rkd, ds_rkd_used, ds_dest,
           ds_gr_we, ds_is_load, ds_issue, ms_ld_done, ms_ld_dest,
           ws_we, ws_dest, flush,
    input  ds_stall, busy_vec, err
  );

  // Scoreboard side.
  modport slave (
    input  ds_valid, ds_rj, ds_rj_used, ds_rkd, ds_rkd_used, ds_dest,
           ds_gr_we, ds_is_load, ds_issue, ms_ld_done, ms_ld_dest,
           ws_we, ws_dest, flush,
    output ds_stall, busy_vec, err
  );

endinterface

// File: rtl/reg_scoreboard_counter.sv
// One per-register up/down occupancy counter with same-cycle bypass flag.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_inc,
  input  logic i_dec,
  input  logic i_clr,
  output logic o_nz,
  output logic o_max,
  output logic o_eff_nz,
  output logic o_underflow
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_one;

  assign o_nz  = (r_cnt != '0);
  assign o_max = &r_cnt;
  assign w_one = (r_cnt == CNT_W'(1));

  // Count as seen by ID this cycle: a decrement in flight already frees the value.
  assign o_eff_nz = o_nz && !(i_dec && w_one);

  // A lone decrement of an empty counter; a paired inc/dec cancels out.
  assign o_underflow = i_dec && !i_inc && !o_nz;

  // Counter update: clear wins, paired inc/dec holds, decrement floors at zero.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end else if (i_dec && !i_inc && o_nz) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// Per-register in-flight write/load tracker and ID issue interlock.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int NREG  = SB_NREG,
  parameter int CNT_W = SB_CNT_W,
  parameter int FWD   = 1
) (
  input  logic             clk,
  input  logic             resetn,
  reg_scoreboard_if.slave  sb
);

  logic            w_issue_wr;
  logic            w_issue_ld;
  logic            w_ws_dec;
  logic            w_ms_dec;
  logic [NREG-1:0] w_pend_nz;
  logic [NREG-1:0] w_pend_max;
  logic [NREG-1:0] w_pend_eff_nz;
  logic [NREG-1:0] w_pend_uf;
  logic [NREG-1:0] w_ld_eff_nz;
  logic [NREG-1:0] w_ld_uf;
  logic [NREG-1:0] w_unused_ld_nz;
  logic [NREG-1:0] w_unused_ld_max;
  logic [NREG-1:0] w_src_hz;
  logic            w_ds_stall;
  logic            r_err;

  assign w_issue_wr = sb.ds_issue && sb.ds_gr_we && (sb.ds_dest != REG_ZERO);
  assign w_issue_ld = w_issue_wr && sb.ds_is_load;
  assign w_ws_dec   = sb.ws_we && (sb.ws_dest != REG_ZERO);
  assign w_ms_dec   = sb.ms_ld_done && (sb.ms_ld_dest != REG_ZERO);

  // r0 has no counters: its flags are constant zero.
  assign w_pend_nz[0]       = 1'b0;
  assign w_pend_max[0]      = 1'b0;
  assign w_pend_eff_nz[0]   = 1'b0;
  assign w_pend_uf[0]       = 1'b0;
  assign w_ld_eff_nz[0]     = 1'b0;
  assign w_ld_uf[0]         = 1'b0;
  assign w_unused_ld_nz[0]  = 1'b0;
  assign w_unused_ld_max[0] = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_reg
    sb_counter #(.CNT_W(CNT_W)) u_pend (
      .clk         (clk),
      .resetn      (resetn),
      .i_inc       (w_issue_wr && (sb.ds_dest == reg_idx_t'(i))),
      .i_dec       (w_ws_dec && (sb.ws_dest == reg_idx_t'(i))),
      .i_clr       (sb.flush),
      .o_nz        (w_pend_nz[i]),
      .o_max       (w_pend_max[i]),
      .o_eff_nz    (w_pend_eff_nz[i]),
      .o_underflow (w_pend_uf[i])
    );

    // Load occupancy never exceeds pend occupancy, so its nz/max go unused.
    sb_counter #(.CNT_W(CNT_W)) u_ld (
      .clk         (clk),
      .resetn      (resetn),
      .i_inc       (w_issue_ld && (sb.ds_dest == reg_idx_t'(i))),
      .i_dec       (w_ms_dec && (sb.ms_ld_dest == reg_idx_t'(i))),
      .i_clr       (sb.flush),
      .o_nz        (w_unused_ld_nz[i]),
      .o_max       (w_unused_ld_max[i]),
      .o_eff_nz    (w_ld_eff_nz[i]),
      .o_underflow (w_ld_uf[i])
    );
  end

  // With forwarding only unfinished loads block a reader; without it any write does.
  assign w_src_hz = (FWD != 0) ? w_ld_eff_nz : w_pend_eff_nz;

  // Issue interlock: source hazards plus a full destination counter.
  // NOTE: the output gets its default before any branch so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_ds_stall = 1'b0;
    if (sb.ds_valid) begin
      if (sb.ds_rj_used && w_src_hz[sb.ds_rj]) begin
        w_ds_stall = 1'b1;
      end
      if (sb.ds_rkd_used && w_src_hz[sb.ds_rkd]) begin
        w_ds_stall = 1'b1;
      end
      if (sb.ds_gr_we && (sb.ds_dest != REG_ZERO) && w_pend_max[sb.ds_dest]) begin
        w_ds_stall = 1'b1;
      end
    end
  end

  // Sticky underflow flag; only reset clears it, flush leaves it alone.
  // NOTE: every counter and this flag have an asynchronous reset because the
  // tracking state must be empty the moment the pipeline is reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err <= 1'b0;
    end else if ((|w_pend_uf) || (|w_ld_uf)) begin
      r_err <= 1'b1;
    end
  end

  assign sb.ds_stall = w_ds_stall;
  assign sb.busy_vec = w_pend_nz;
  assign sb.err      = r_err;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed scoreboard bench: one stimulus stream drives a FWD=1 and a FWD=0 instance.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  typedef struct {
    string       name;
    bit          s1;
    bit          s0;
    logic [31:0] busy;
    bit          err;
  } exp_t;

  logic     clk;
  logic     resetn;
  logic     ds_valid, ds_rj_used, ds_rkd_used, ds_gr_we, ds_is_load, ds_issue;
  logic     ms_ld_done, ws_we, flush;
  reg_idx_t ds_rj, ds_rkd, ds_dest, ms_ld_dest, ws_dest;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  reg_scoreboard_if #(.NREG(32)) sb1 ();
  reg_scoreboard_if #(.NREG(32)) sb0 ();

  assign sb1.ds_valid = ds_valid;     assign sb0.ds_valid = ds_valid;
  assign sb1.ds_rj = ds_rj;           assign sb0.ds_rj = ds_rj;
  assign sb1.ds_rj_used = ds_rj_used; assign sb0.ds_rj_used = ds_rj_used;
  assign sb1.ds_rkd = ds_rkd;         assign sb0.ds_rkd = ds_rkd;
  assign sb1.ds_rkd_used = ds_rkd_used; assign sb0.ds_rkd_used = ds_rkd_used;
  assign sb1.ds_dest = ds_dest;       assign sb0.ds_dest = ds_dest;
  assign sb1.ds_gr_we = ds_gr_we;     assign sb0.ds_gr_we = ds_gr_we;
  assign sb1.ds_is_load = ds_is_load; assign sb0.ds_is_load = ds_is_load;
  assign sb1.ds_issue = ds_issue;     assign sb0.ds_issue = ds_issue;
  assign sb1.ms_ld_done = ms_ld_done; assign sb0.ms_ld_done = ms_ld_done;
  assign sb1.ms_ld_dest = ms_ld_dest; assign sb0.ms_ld_dest = ms_ld_dest;
  assign sb1.ws_we = ws_we;           assign sb0.ws_we = ws_we;
  assign sb1.ws_dest = ws_dest;       assign sb0.ws_dest = ws_dest;
  assign sb1.flush = flush;           assign sb0.flush = flush;

  reg_scoreboard #(.NREG(32), .CNT_W(2), .FWD(1)) u_dut_fwd1 (
    .clk    (clk),
    .resetn (resetn),
    .sb     (sb1)
  );

  reg_scoreboard #(.NREG(32), .CNT_W(2), .FWD(0)) u_dut_fwd0 (
    .clk    (clk),
    .resetn (resetn),
    .sb     (sb0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every expectation is compared mid-cycle, away from the rising edge.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check({e.name, "/stall_fwd1"}, 32'(sb1.ds_stall), 32'(e.s1));
      check({e.name, "/stall_fwd0"}, 32'(sb0.ds_stall), 32'(e.s0));
      check({e.name, "/busy_fwd1"},  sb1.busy_vec,      e.busy);
      check({e.name, "/busy_fwd0"},  sb0.busy_vec,      e.busy);
      check({e.name, "/err_fwd1"},   32'(sb1.err),      32'(e.err));
      check({e.name, "/err_fwd0"},   32'(sb0.err),      32'(e.err));
    end
  end

  function automatic logic [31:0] rb(input int n);
    return 32'd1 << n;
  endfunction

  task automatic idle();
    ds_valid = 0; ds_rj = 0; ds_rj_used = 0; ds_rkd = 0; ds_rkd_used = 0;
    ds_dest = 0; ds_gr_we = 0; ds_is_load = 0; ds_issue = 0;
    ms_ld_done = 0; ms_ld_dest = 0; ws_we = 0; ws_dest = 0; flush = 0;
  endtask

  task automatic issue_wr(input reg_idx_t d, input bit ld);
    ds_valid = 1; ds_gr_we = 1; ds_dest = d; ds_is_load = ld; ds_issue = 1;
  endtask

  task automatic hold_wr(input reg_idx_t d);
    ds_valid = 1; ds_gr_we = 1; ds_dest = d;
  endtask

  task automatic read_rj(input reg_idx_t r);
    ds_valid = 1; ds_rj = r; ds_rj_used = 1;
  endtask

  task automatic read_rkd(input reg_idx_t r);
    ds_valid = 1; ds_rkd = r; ds_rkd_used = 1;
  endtask

  task automatic retire(input reg_idx_t r);
    ws_we = 1; ws_dest = r;
  endtask

  task automatic ld_done(input reg_idx_t r);
    ms_ld_done = 1; ms_ld_dest = r;
  endtask

  // Queue the expectation for the current cycle's inputs, then advance one cycle.
  task automatic cyc(input string name, input bit s1, input bit s0,
                     input logic [31:0] busy, input bit err);
    exp_t e;
    e.name = name; e.s1 = s1; e.s0 = s0; e.busy = busy; e.err = err;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    resetn = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    read_rj(5); cyc("reset_hold", 0, 0, 0, 0);
    resetn = 1'b1;

    // Load-use: ld.w r5 followed by a reader of r5.
    issue_wr(5, 1);                       cyc("ld_issue",  0, 0, 0, 0);
    read_rj(5); hold_wr(6);               cyc("ld_use1",   1, 1, rb(5), 0);
    read_rj(5); hold_wr(6);               cyc("ld_use2",   1, 1, rb(5), 0);
    read_rj(5); hold_wr(6); ld_done(5);   cyc("ld_bypass", 0, 1, rb(5), 0);
    read_rj(5); hold_wr(6);               cyc("ld_after",  0, 1, rb(5), 0);
    read_rj(5); issue_wr(6, 0); retire(5); cyc("ws_bypass", 0, 0, rb(5), 0);
    retire(6);                            cyc("busy6",     0, 0, rb(6), 0);
    cyc("idle_a", 0, 0, 0, 0);

    // ALU chain: add.w r3 then addi.w r4 reading r3.
    issue_wr(3, 0); read_rj(1);           cyc("alu_issue",  0, 0, 0, 0);
    issue_wr(4, 0); read_rj(3);           cyc("alu_dep",    0, 1, rb(3), 0);
    retire(3);                            cyc("alu_busy34", 0, 0, rb(3) | rb(4), 0);
    retire(4);                            cyc("alu_busy4",  0, 0, rb(4), 0);
    cyc("alu_idle", 0, 0, 0, 0);

    // Back-to-back writes to r7 up to the counter limit.
    issue_wr(7, 0);                       cyc("r7_w1",      0, 0, 0, 0);
    issue_wr(7, 0);                       cyc("r7_w2",      0, 0, rb(7), 0);
    issue_wr(7, 0);                       cyc("r7_w3",      0, 0, rb(7), 0);
    hold_wr(7);                           cyc("r7_full",    1, 1, rb(7), 0);
    hold_wr(7); retire(7);                cyc("r7_full_ws", 1, 1, rb(7), 0);
    issue_wr(7, 0);                       cyc("r7_w4",      0, 0, rb(7), 0);
    read_rj(7); retire(7);                cyc("r7_read",    0, 1, rb(7), 0);
    retire(7);                            cyc("r7_dr1",     0, 0, rb(7), 0);
    retire(7);                            cyc("r7_dr2",     0, 0, rb(7), 0);
    cyc("r7_idle", 0, 0, 0, 0);

    // Issue and retire of r9 in the same cycle.
    issue_wr(9, 0);                       cyc("r9_w1",   0, 0, 0, 0);
    issue_wr(9, 0); read_rkd(9); retire(9); cyc("r9_same", 0, 0, rb(9), 0);
    read_rkd(9);                          cyc("r9_read", 0, 1, rb(9), 0);
    retire(9);                            cyc("r9_ret",  0, 0, rb(9), 0);

    // r0 is never tracked and never underflows.
    issue_wr(0, 1); read_rj(0); read_rkd(0); cyc("r0_issue", 0, 0, 0, 0);
    retire(0); ld_done(0); read_rj(0);    cyc("r0_idle",  0, 0, 0, 0);
    cyc("r0_noerr", 0, 0, 0, 0);

    // Flush beats a same-cycle issue.
    issue_wr(2, 1);                       cyc("fl_ld",    0, 0, 0, 0);
    issue_wr(2, 0);                       cyc("fl_add",   0, 0, rb(2), 0);
    read_rj(2);                           cyc("fl_pre",   1, 1, rb(2), 0);
    issue_wr(2, 1); flush = 1;            cyc("fl_flush", 0, 0, rb(2), 0);
    read_rj(2); read_rkd(2); hold_wr(2);  cyc("fl_after", 0, 0, 0, 0);

    // Write-back underflow on r12.
    retire(12);                           cyc("uf_ws",   0, 0, 0, 0);
    issue_wr(12, 0);                      cyc("uf_err",  0, 0, 0, 1);
    retire(12);                           cyc("uf_cnt",  0, 0, rb(12), 1);
    issue_wr(20, 0);                      cyc("uf_idle", 0, 0, 0, 1);
    read_rj(20);                          cyc("pre_rst", 0, 1, rb(20), 1);

    // Reset asserted mid-cycle takes effect before the next edge.
    resetn = 1'b0; read_rj(20);           cyc("rst_async", 0, 0, 0, 0);
    cyc("rst_hold", 0, 0, 0, 0);
    resetn = 1'b1;                        cyc("rst_rel",  0, 0, 0, 0);

    // Load-side underflow, and flush leaving err set.
    ld_done(13);                          cyc("ld_uf",     0, 0, 0, 0);
    flush = 1;                            cyc("ld_uf_err", 0, 0, 0, 1);
    cyc("flush_keeps_err", 0, 0, 0, 1);

    for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
